bsg_serial_in_parallel_out_buffered: RTL and testbench
======================================================

# bsg_serial_in_parallel_out_buffered

Reassembles a stream of single `width_p` words into one `els_p`-word parallel output. It sits directly downstream of the passthrough PISO, on the far side of a narrow link, and rebuilds the original wide transaction. The input side is a ready/valid consumer and the output side is a registered ready/valid producer. With back-to-back traffic it sustains one serial word per cycle with no bubbles.

## Interface
- `width_p`, default -1 (must be set): bits per serial word.
- `els_p`, default -1 (must be set, ≥1): serial words per parallel output.
- `hi_to_lo_p`, default 0: 0 places the first received word at `data_o[0]`; 1 places it at `data_o[els_p-1]`.

Ports:
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `v_i`  in  1  serial word valid.
- `data_i`  in  `width_p`  serial word.
- `ready_and_o`  out  1  block can accept `data_i` this cycle; a word transfers when `v_i & ready_and_o`.
- `v_o`  out  1  parallel output holds a complete assembled word.
- `data_o`  out  `[els_p-1:0][width_p-1:0]`  assembled words.
- `ready_and_i`  in  1  consumer accepts; an output transfer occurs when `v_o & ready_and_i`.

## Operation
**State**
- One-hot write pointer `wptr_r` (`els_p` bits).
  - Reset value `1` (slot 0).
  - Built from `bsg_counter_clear_up_one_hot`, `max_val_p = els_p-1`, `init_val_p = 1`.
- Full flag `full_r`; reset value 0.
- `els_p` data registers. These are not reset; `data_o` is don't-care while `v_o = 0`.

**Outputs**
- `v_o = full_r`.
- `ready_and_o = ~full_r | ready_and_i`. The input accepts while the buffer is empty/filling, or in the same cycle the full buffer drains.
- `data_o` is driven directly from the data registers. It is reversed when `hi_to_lo_p = 1` (word received k appears at index `els_p-1-k`).

**On each input transfer** (`v_i & ready_and_o`)
- Write `data_i` into the slot selected by `wptr_r`.
- If `wptr_r[els_p-1]` (last slot):
  - set `full_r`;
  - clear `wptr_r` to slot 0.
- Otherwise, advance `wptr_r` one position.

**On each output transfer** (`v_o & ready_and_i`)
- Clear `full_r`, unless the same cycle's input transfer fills the last slot. That can only happen when `els_p = 1`, in which case `full_r` stays 1.

**Input/output overlap**
- While full and draining, an input word is written to slot 0. This is safe because the old contents are consumed that same cycle.
- Slots 1..`els_p-1` keep old data until overwritten; `v_o` stays low until the new word completes.

**Single-word case** (`els_p = 1`)
- The block degenerates to a one-entry registered buffer with full throughput.
- `ready_and_o = ~full_r | ready_and_i`.

**Reset**
- `reset_i` mid-assembly discards the partial words.
- The first post-reset transfer lands in slot 0.
- `ready_and_o = 1` and `v_o = 0` in the cycle after reset is sampled, and they remain so while `reset_i` is held.
- Inputs are ignored while `reset_i = 1`.

**Simulation-only checks**
- Assert that `v_i`, `ready_and_i` and `data_i` are never X when not in reset.

## Timing
- Latency: the input transfer of the last word in cycle N gives `v_o = 1` in cycle N+1 with the complete `data_o`.
- Throughput: `els_p` consecutive input transfers produce one output, with no idle cycles, while `ready_and_i` is high when `v_o` is high.
- Backpressure:
  - With `full_r = 1` and `ready_and_i = 0`, `ready_and_o = 0`.
  - `data_o` and `v_o` hold stable until the output transfer.
- Combinational path: `ready_and_i` → `ready_and_o` (one OR gate). There is no combinational path from `v_i` or `data_i` to any output.
- Pointer wrap: slot `els_p-1` → slot 0 on the same edge that sets `full_r`.

## Test plan
- **Basic assembly:** `els_p=4`, `width_p=8`, `ready_and_i=1`; send A0,A1,A2,A3 back-to-back → `v_o` high for exactly one cycle after A3, `data_o = {A3,A2,A1,A0}` (index 0 = A0).
- **hi_to_lo:** same stimulus with `hi_to_lo_p=1` → `data_o[3]=A0`, `data_o[0]=A3`.
- **Backpressure:** fill the buffer with `ready_and_i=0` for 5 cycles → `ready_and_o=0`, `data_o` stable; raise `ready_and_i` with `v_i=1` B0 → same-cycle output transfer and B0 written to slot 0; B1..B3 follow → second output `{B3,B2,B1,B0}`.
- **Streaming:** 64 words, `v_i` and `ready_and_i` always high → 16 outputs, `ready_and_o` never low, each output matches its group.
- **Reset mid-operation:** send C0,C1, assert `reset_i` one cycle, send D0..D3 → single output `{D3,D2,D1,D0}`, no output containing C words.
- **Degenerate case:** `els_p=1`; random `v_i`/`ready_and_i` over 1000 cycles → output order equals input order, no loss or duplication, full throughput when both are high.

Source files
------------

// File: rtl/bsg_serial_in_parallel_out_buffered.sv
// bsg_serial_in_parallel_out_buffered
//
// Collects els_p consecutive width_p-bit serial words into one els_p-word
// parallel output. The serial side is a ready/valid consumer and the parallel
// side is a registered ready/valid producer. A full buffer can be drained and
// refilled in the same cycle, so back-to-back traffic runs without bubbles.
//
// Parameters:
//   width_p     bits per serial word (must be set)
//   els_p       serial words per parallel output (must be set, >= 1)
//   hi_to_lo_p  0: first word at data_o[0]; 1: first word at data_o[els_p-1]
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   reset_i      synchronous active-high reset
//   v_i          serial word valid
//   data_i       serial word
//   ready_and_o  block accepts data_i this cycle
//   v_o          parallel output holds a complete word
//   data_o       assembled words
//   ready_and_i  downstream consumer accepts data_o

// One-hot up counter with synchronous clear.
//   clear_i  load init_val_p (if up_i is also set, load init_val_p advanced once)
//   up_i     advance the hot bit one position, wrapping at max_val_p
module bsg_counter_clear_up_one_hot #(
    parameter int max_val_p  = 1,
    parameter int init_val_p = 1,
    localparam int width_lp  = max_val_p + 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                clear_i,
    input  logic                up_i,
    output logic [width_lp-1:0] count_r_o
);

    localparam logic [width_lp-1:0] init_lp = width_lp'(init_val_p);

    // Rotate the hot bit one position toward the MSB, wrapping to bit 0.
    function automatic logic [width_lp-1:0] rotate_one(input logic [width_lp-1:0] x);
        logic [width_lp-1:0] r;
        r = '0;
        for (int i = 0; i < width_lp; i++) begin
            r[(i + 1) % width_lp] = x[i];
        end
        return r;
    endfunction

    logic [width_lp-1:0] count_r;
    logic [width_lp-1:0] count_nxt_s;

    // Next count value: clear takes priority as the base value, up advances it.
    always_comb begin
        count_nxt_s = count_r;
        if (clear_i && up_i) begin
            count_nxt_s = rotate_one(init_lp);
        end else if (clear_i) begin
            count_nxt_s = init_lp;
        end else if (up_i) begin
            count_nxt_s = rotate_one(count_r);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Counter state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r <= init_lp;
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign count_r_o = count_r;

endmodule

// Simulation-only protocol checks for the SIPO block.
module bsg_serial_in_parallel_out_buffered_checker #(
    parameter int width_lp = 1
) (
    input logic                clk_i,
    input logic                reset_i,
    input logic                v_i,
    input logic                ready_and_i,
    input logic [width_lp-1:0] data_i
);

    // Handshake and data inputs must be known whenever the block is live.
    assert property (@(posedge clk_i) disable iff (reset_i)
        !$isunknown({v_i, ready_and_i, data_i}));

endmodule

module bsg_serial_in_parallel_out_buffered #(
    parameter int width_p    = -1,
    parameter int els_p      = -1,
    parameter int hi_to_lo_p = 0,
    localparam int width_lp  = (width_p > 0) ? width_p : 1,
    localparam int els_lp    = (els_p > 0) ? els_p : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,

    input  logic                             v_i,
    input  logic [width_lp-1:0]              data_i,
    output logic                             ready_and_o,

    output logic                             v_o,
    output logic [els_lp-1:0][width_lp-1:0]  data_o,
    input  logic                             ready_and_i
);

    logic [els_lp-1:0]               wptr_r;
    logic                            full_r;
    logic [els_lp-1:0][width_lp-1:0] data_r;

    logic in_xfer_s;
    logic out_xfer_s;
    logic last_s;
    logic wr_en_s;

    // A full buffer still accepts a word in the cycle it drains; that word
    // lands in slot 0, whose old contents leave on the same edge.
    assign ready_and_o = ~full_r | ready_and_i;
    assign v_o         = full_r;

    assign in_xfer_s  = v_i & ready_and_o;
    assign out_xfer_s = full_r & ready_and_i;
    assign last_s     = wptr_r[els_lp-1];
    assign wr_en_s    = in_xfer_s & ~reset_i;

    bsg_counter_clear_up_one_hot #(
        .max_val_p  (els_lp - 1),
        .init_val_p (1)
    ) wptr_cnt (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (in_xfer_s & last_s),
        .up_i      (in_xfer_s & ~last_s),
        .count_r_o (wptr_r)
    );

    // Full flag: filling the last slot wins over a same-cycle drain, which
    // keeps a single-slot buffer full when it is refilled while draining.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            full_r <= 1'b0;
        end else if (in_xfer_s && last_s) begin
            full_r <= 1'b1;
        end else if (out_xfer_s) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

    // Data slots are not reset; their contents only matter while v_o is high.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < els_lp; i++) begin
            if (wr_en_s && wptr_r[i]) begin
                data_r[i] <= data_i;
            end else begin
                data_r[i] <= data_r[i];
            end
        end
    end

    for (genvar k = 0; k < els_lp; k++) begin : g_out
        if (hi_to_lo_p != 0) begin : g_rev
            assign data_o[k] = data_r[els_lp-1-k];
        end else begin : g_fwd
            assign data_o[k] = data_r[k];
        end
    end

    bsg_serial_in_parallel_out_buffered_checker #(
        .width_lp (width_lp)
    ) chk (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .v_i         (v_i),
        .ready_and_i (ready_and_i),
        .data_i      (data_i)
    );

endmodule

// File: tb/tb_bsg_serial_in_parallel_out_buffered.sv
module tb_bsg_serial_in_parallel_out_buffered;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;

    // els_p = 4 instances (low-to-high and high-to-low) share stimulus
    logic             v4 = 1'b0, rdy4 = 1'b0;
    logic [7:0]       d4 = 8'h00;
    logic             r4o, v4o, r4ho, v4ho;
    logic [3:0][7:0]  q4, q4h;

    // els_p = 1 instance
    logic             v1 = 1'b0, rdy1 = 1'b0;
    logic [7:0]       d1 = 8'h00;
    logic             r1o, v1o;
    logic [0:0][7:0]  q1;

    int tests = 0;
    int fails = 0;

    // Reference model: a list of accepted words and one pending assembled group.
    bit          m4_full = 1'b0;
    logic [31:0] m4_data;
    logic [7:0]  m4_acc[$];
    bit          m1_full = 1'b0;
    logic [7:0]  m1_data;
    int          m1_sent = 0;
    int          m1_recv = 0;

    bsg_serial_in_parallel_out_buffered #(.width_p(8), .els_p(4), .hi_to_lo_p(0)) dut4 (
        .clk_i(clk), .reset_i(reset), .v_i(v4), .data_i(d4), .ready_and_o(r4o),
        .v_o(v4o), .data_o(q4), .ready_and_i(rdy4));

    bsg_serial_in_parallel_out_buffered #(.width_p(8), .els_p(4), .hi_to_lo_p(1)) dut4h (
        .clk_i(clk), .reset_i(reset), .v_i(v4), .data_i(d4), .ready_and_o(r4ho),
        .v_o(v4ho), .data_o(q4h), .ready_and_i(rdy4));

    bsg_serial_in_parallel_out_buffered #(.width_p(8), .els_p(1), .hi_to_lo_p(0)) dut1 (
        .clk_i(clk), .reset_i(reset), .v_i(v1), .data_i(d1), .ready_and_o(r1o),
        .v_o(v1o), .data_o(q1), .ready_and_i(rdy1));

    function automatic logic [31:0] rev4(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // One cycle on the els_p=4 pair: drive, check against model, advance model.
    task automatic cyc4(input bit v, input logic [7:0] d, input bit rdy, output bit out_x);
        bit exp_rdy;
        @(negedge clk);
        v4 = v; d4 = d; rdy4 = rdy;
        #1;
        exp_rdy = !m4_full || rdy;
        tests++; if (r4o !== exp_rdy) begin fails++; $display("FAIL ready4 got %b exp %b t=%0t", r4o, exp_rdy, $time); end
        tests++; if (r4ho !== exp_rdy) begin fails++; $display("FAIL ready4h got %b exp %b t=%0t", r4ho, exp_rdy, $time); end
        tests++; if (v4o !== m4_full) begin fails++; $display("FAIL v4 got %b exp %b t=%0t", v4o, m4_full, $time); end
        tests++; if (v4ho !== m4_full) begin fails++; $display("FAIL v4h got %b exp %b t=%0t", v4ho, m4_full, $time); end
        out_x = m4_full && rdy;
        if (out_x) begin
            tests++; if (q4 !== m4_data) begin fails++; $display("FAIL data4 got %h exp %h t=%0t", q4, m4_data, $time); end
            tests++; if (q4h !== rev4(m4_data)) begin fails++; $display("FAIL data4h got %h exp %h t=%0t", q4h, rev4(m4_data), $time); end
            m4_full = 1'b0;
        end
        if (v && exp_rdy) begin
            m4_acc.push_back(d);
            if (m4_acc.size() == 4) begin
                m4_data = {m4_acc[3], m4_acc[2], m4_acc[1], m4_acc[0]};
                m4_acc.delete();
                m4_full = 1'b1;
            end
        end
    endtask

    // One cycle on the els_p=1 instance.
    task automatic cyc1(input bit v, input logic [7:0] d, input bit rdy);
        bit exp_rdy;
        @(negedge clk);
        v1 = v; d1 = d; rdy1 = rdy;
        #1;
        exp_rdy = !m1_full || rdy;
        tests++; if (r1o !== exp_rdy) begin fails++; $display("FAIL ready1 got %b exp %b t=%0t", r1o, exp_rdy, $time); end
        tests++; if (v1o !== m1_full) begin fails++; $display("FAIL v1 got %b exp %b t=%0t", v1o, m1_full, $time); end
        if (m1_full && rdy) begin
            tests++; if (q1 !== m1_data) begin fails++; $display("FAIL data1 got %h exp %h t=%0t", q1, m1_data, $time); end
            m1_full = 1'b0;
            m1_recv++;
        end
        if (v && exp_rdy) begin
            m1_data = d;
            m1_full = 1'b1;
            m1_sent++;
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b1;
            v4 = 1'b1; d4 = 8'($urandom); rdy4 = 1'($urandom);
            v1 = 1'b1; d1 = 8'($urandom); rdy1 = 1'($urandom);
            @(posedge clk);
            #1;
            tests++; if (r4o !== 1'b1 || r4ho !== 1'b1 || r1o !== 1'b1) begin
                fails++; $display("FAIL reset_ready got %b%b%b exp 111", r4o, r4ho, r1o); end
            tests++; if (v4o !== 1'b0 || v4ho !== 1'b0 || v1o !== 1'b0) begin
                fails++; $display("FAIL reset_valid got %b%b%b exp 000", v4o, v4ho, v1o); end
        end
        @(negedge clk);
        reset = 1'b0;
        v4 = 1'b0; rdy4 = 1'b0; v1 = 1'b0; rdy1 = 1'b0;
        m4_full = 1'b0; m4_acc.delete();
        m1_full = 1'b0; m1_sent = 0; m1_recv = 0;
    endtask

    task automatic test_reset();
        do_reset(3);
    endtask

    task automatic test_basic();
        bit ox;
        int outs = 0;
        for (int i = 0; i < 4; i++) begin
            cyc4(1'b1, 8'($urandom), 1'b1, ox);
            if (ox) outs++;
        end
        for (int i = 0; i < 4; i++) begin
            cyc4(1'b0, 8'h00, 1'b1, ox);
            if (ox) outs++;
        end
        tests++; if (outs !== 1) begin fails++; $display("FAIL basic_outs got %0d exp 1", outs); end
    endtask

    task automatic test_backpressure();
        bit ox;
        logic [31:0] snap;
        for (int i = 0; i < 4; i++) cyc4(1'b1, 8'($urandom), 1'b0, ox);
        snap = m4_data;
        for (int i = 0; i < 5; i++) begin
            cyc4(1'b1, 8'($urandom), 1'b0, ox);
            tests++; if (r4o !== 1'b0) begin fails++; $display("FAIL bp_ready got %b exp 0", r4o); end
            tests++; if (q4 !== snap) begin fails++; $display("FAIL bp_stable got %h exp %h", q4, snap); end
        end
        cyc4(1'b1, 8'($urandom), 1'b1, ox);
        tests++; if (ox !== 1'b1 || r4o !== 1'b1) begin
            fails++; $display("FAIL bp_overlap got out=%b rdy=%b exp 1 1", ox, r4o); end
        for (int i = 0; i < 3; i++) cyc4(1'b1, 8'($urandom), 1'b1, ox);
        for (int i = 0; i < 2; i++) cyc4(1'b0, 8'h00, 1'b1, ox);
    endtask

    task automatic test_streaming();
        bit ox;
        int outs = 0;
        int lows = 0;
        for (int i = 0; i < 65; i++) begin
            cyc4(i < 64, 8'($urandom), 1'b1, ox);
            if (ox) outs++;
            if (r4o !== 1'b1) lows++;
        end
        tests++; if (outs !== 16) begin fails++; $display("FAIL stream_outs got %0d exp 16", outs); end
        tests++; if (lows !== 0) begin fails++; $display("FAIL stream_ready_low got %0d exp 0", lows); end
    endtask

    task automatic test_reset_mid();
        bit ox;
        int outs = 0;
        cyc4(1'b1, 8'hC0, 1'b1, ox);
        cyc4(1'b1, 8'hC1, 1'b1, ox);
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            cyc4(1'b1, 8'hD0 + 8'(i), 1'b1, ox);
            if (ox) outs++;
        end
        for (int i = 0; i < 3; i++) begin
            cyc4(1'b0, 8'h00, 1'b1, ox);
            if (ox) outs++;
        end
        tests++; if (outs !== 1) begin fails++; $display("FAIL reset_mid_outs got %0d exp 1", outs); end
    endtask

    task automatic test_random4();
        bit ox;
        for (int i = 0; i < 300; i++) cyc4(1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0), ox);
        for (int i = 0; i < 2; i++) cyc4(1'b0, 8'h00, 1'b1, ox);
    endtask

    task automatic test_degenerate();
        for (int i = 0; i < 1000; i++) cyc1(1'($urandom), 8'($urandom), 1'($urandom));
        cyc1(1'b0, 8'h00, 1'b1);
        cyc1(1'b0, 8'h00, 1'b1);
        tests++; if (m1_recv !== m1_sent) begin fails++; $display("FAIL deg_count got %0d exp %0d", m1_recv, m1_sent); end
        for (int i = 0; i < 20; i++) cyc1(1'b1, 8'($urandom), 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        test_random4();
        test_degenerate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
